// File: rtl/mem_wb_pkg.sv
// Shared constants and payload layout for the MEM->WB pipeline register.
package mem_wb_pkg;

  localparam int XLEN     = 32;
  localparam int WB_SEL_W = 2;
  localparam int RD_W     = 5;

  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd0;
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd1;
  localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]     jump_result_plus4;
    logic [XLEN-1:0]     mem_result;
    logic [XLEN-1:0]     alu_out;
    logic [WB_SEL_W-1:0] wb_sel;
    logic                reg_write;
    logic [RD_W-1:0]     rd;
  } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_pipe_stage_if.sv
// Handshake and payload bundle between the memory stage, the MEM->WB register and writeback.
interface mem_wb_pipe_stage_if
  import mem_wb_pkg::*;
#(
  parameter int XLEN     = mem_wb_pkg::XLEN,
  parameter int WB_SEL_W = mem_wb_pkg::WB_SEL_W,
  parameter int RD_W     = mem_wb_pkg::RD_W,
  parameter int CNT_W    = 16
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [XLEN-1:0]     jump_result_plus4M;
  logic [XLEN-1:0]     mem_resultM;
  logic [XLEN-1:0]     alu_outM;
  logic [WB_SEL_W-1:0] wb_selM;
  logic                reg_writeM;
  logic [RD_W-1:0]     rdM;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     jump_result_plus4W;
  logic [XLEN-1:0]     mem_resultW;
  logic [XLEN-1:0]     alu_outW;
  logic [WB_SEL_W-1:0] wb_selW;
  logic                reg_writeW;
  logic [RD_W-1:0]     rdW;
  logic [CNT_W-1:0]    bubble_cnt;

  modport master (
    output flush, in_valid, jump_result_plus4M, mem_resultM, alu_outM, wb_selM,
           reg_writeM, rdM, out_ready,
    input  in_ready, out_valid, jump_result_plus4W, mem_resultW, alu_outW, wb_selW,
           reg_writeW, rdW, bubble_cnt
  );

  modport slave (
    input  flush, in_valid, jump_result_plus4M, mem_resultM, alu_outM, wb_selM,
           reg_writeM, rdM, out_ready,
    output in_ready, out_valid, jump_result_plus4W, mem_resultW, alu_outW, wb_selW,
           reg_writeW, rdW, bubble_cnt
  );
endinterface

// File: rtl/mem_wb_pipe_stage_slot.sv
// One payload+valid register: clear beats load, otherwise hold.
module mem_wb_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] payload
);
  logic         valid_q, valid_d;
  logic [W-1:0] payload_q, payload_d;

  always_comb begin
    // NOTE: defaults first so every path assigns the next state and no latch is inferred.
    valid_d   = valid_q;
    payload_d = payload_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      payload_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the payload is reset too, so a freshly reset stage presents all-zero outputs.
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid   = valid_q;
  assign payload = payload_q;
endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline register with valid/ready, flush and gated reg-write.
// Define MEM_WB_SKID_EN to add a skid slot and a registered in_ready.
module mem_wb_pipe_stage
  import mem_wb_pkg::*;
#(
  parameter int XLEN     = mem_wb_pkg::XLEN,
  parameter int WB_SEL_W = mem_wb_pkg::WB_SEL_W,
  parameter int RD_W     = mem_wb_pkg::RD_W,
  parameter int CNT_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_pipe_stage_if.slave bus
);
  localparam int PW = 3 * XLEN + WB_SEL_W + 1 + RD_W;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_payload;
  logic [PW-1:0] main_d;
  logic          main_valid;
  logic          main_load;
  logic          main_clear;
  logic          accept;
  logic          transfer;

  assign in_payload = {bus.jump_result_plus4M, bus.mem_resultM, bus.alu_outM,
                       bus.wb_selM, bus.reg_writeM, bus.rdM};
  assign accept     = bus.in_valid && bus.in_ready;
  assign transfer   = main_valid && bus.out_ready;

`ifdef MEM_WB_SKID_EN
  logic          skid_valid;
  logic          skid_load;
  logic          skid_clear;
  logic [PW-1:0] skid_payload;

  // in_ready comes straight from a flop: the skid slot absorbs the one-cycle lag.
  assign bus.in_ready = !skid_valid;

  always_comb begin
    main_load  = 1'b0;
    main_clear = bus.flush;
    main_d     = in_payload;
    skid_load  = 1'b0;
    skid_clear = bus.flush;
    if (!bus.flush) begin
      if (transfer) begin
        if (skid_valid) begin
          main_load  = 1'b1;
          main_d     = skid_payload;
          skid_clear = 1'b1;
        end else if (accept) begin
          main_load = 1'b1;
        end else begin
          main_clear = 1'b1;
        end
      end else if (accept) begin
        if (main_valid) skid_load = 1'b1;
        else            main_load = 1'b1;
      end
    end
  end

  mem_wb_slot #(.W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .d       (in_payload),
    .valid   (skid_valid),
    .payload (skid_payload)
  );
`else
  assign bus.in_ready = !main_valid || bus.out_ready;

  always_comb begin
    main_d     = in_payload;
    main_load  = !bus.flush && accept;
    main_clear = bus.flush || (transfer && !accept);
  end
`endif

  mem_wb_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (main_load),
    .clear   (main_clear),
    .d       (main_d),
    .valid   (main_valid),
    .payload (main_payload)
  );

  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!main_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bubble_cnt_q <= '0;
    else        bubble_cnt_q <= bubble_cnt_d;
  end

  logic held_reg_write;

  assign {bus.jump_result_plus4W, bus.mem_resultW, bus.alu_outW,
          bus.wb_selW, held_reg_write, bus.rdW} = main_payload;

  // A squashed or empty slot must never write the register file.
  assign bus.reg_writeW = held_reg_write && main_valid;
  assign bus.out_valid  = main_valid;
  assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Scoreboard bench for mem_wb_pipe_stage: directed scenarios plus randomized traffic.
module tb_mem_wb_pipe_stage;
  import mem_wb_pkg::*;

  localparam int CNT_W = 4;
  localparam int BMAX  = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_pipe_stage_if #(.CNT_W(CNT_W)) bus ();
  mem_wb_pipe_stage #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  mem_wb_payload_t sb[$];
  int tests = 0;
  int fails = 0;
  int exp_bubble = 0;
  bit exp_in_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic mem_wb_payload_t rand_payload();
    mem_wb_payload_t p;
    p.jump_result_plus4 = $urandom;
    p.mem_result        = $urandom;
    p.alu_out           = $urandom;
    p.wb_sel            = 2'($urandom_range(0, 2));
    p.reg_write         = 1'($urandom_range(0, 1));
    p.rd                = 5'($urandom);
    return p;
  endfunction

  // Drive one cycle's inputs on the falling edge; after the monitor has sampled,
  // record what the coming rising edge does to the stage's contents.
  task automatic step(input bit v, input mem_wb_payload_t p, input bit ordy, input bit fl);
    @(negedge clk);
    bus.in_valid           = v;
    bus.jump_result_plus4M = p.jump_result_plus4;
    bus.mem_resultM        = p.mem_result;
    bus.alu_outM           = p.alu_out;
    bus.wb_selM            = p.wb_sel;
    bus.reg_writeM         = p.reg_write;
    bus.rdM                = p.rd;
    bus.out_ready          = ordy;
    bus.flush              = fl;
    #2;
    if (fl) sb.delete();
    else if (v && exp_in_ready) sb.push_back(p);
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, rand_payload(), ordy, 1'b0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        sb.delete();
        exp_bubble   = 0;
        exp_in_ready = 1'b0;
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst alu_outW", 64'(bus.alu_outW), 64'd0);
        check("rst mem_resultW", 64'(bus.mem_resultW), 64'd0);
        check("rst jump_result_plus4W", 64'(bus.jump_result_plus4W), 64'd0);
        check("rst wb_selW", 64'(bus.wb_selW), 64'd0);
        check("rst rdW", 64'(bus.rdW), 64'd0);
        check("rst reg_writeW", 64'(bus.reg_writeW), 64'd0);
        check("rst bubble_cnt", 64'(bus.bubble_cnt), 64'd0);
      end else begin
`ifdef MEM_WB_SKID_EN
        exp_in_ready = (sb.size() < 2);
`else
        exp_in_ready = (sb.size() == 0) || bus.out_ready;
`endif
        check("in_ready", 64'(bus.in_ready), 64'(exp_in_ready));
        check("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        check("bubble_cnt", 64'(bus.bubble_cnt), 64'(exp_bubble));
        if (sb.size() != 0) begin
          check("jump_result_plus4W", 64'(bus.jump_result_plus4W), 64'(sb[0].jump_result_plus4));
          check("mem_resultW", 64'(bus.mem_resultW), 64'(sb[0].mem_result));
          check("alu_outW", 64'(bus.alu_outW), 64'(sb[0].alu_out));
          check("wb_selW", 64'(bus.wb_selW), 64'(sb[0].wb_sel));
          check("rdW", 64'(bus.rdW), 64'(sb[0].rd));
          check("reg_writeW", 64'(bus.reg_writeW), 64'(sb[0].reg_write));
          if (bus.out_ready) void'(sb.pop_front());
        end else begin
          check("reg_writeW gated", 64'(bus.reg_writeW), 64'd0);
          if (exp_bubble < BMAX) exp_bubble++;
        end
      end
    end
  end

  initial begin : driver
    mem_wb_payload_t p;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.jump_result_plus4M = '0; bus.mem_resultM = '0; bus.alu_outM = '0;
    bus.wb_selM = '0; bus.reg_writeM = 1'b0; bus.rdM = '0;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) begin
      p = rand_payload();
      p.alu_out = 32'(i);
      step(1'b1, p, 1'b1, 1'b0);
    end
    idle(1'b1);

    // Back-pressure with rd=5 held, rd=6 offered.
    p = rand_payload(); p.rd = 5'd5;
    step(1'b1, p, 1'b0, 1'b0);
    p = rand_payload(); p.rd = 5'd6;
    step(1'b1, p, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    repeat (3) idle(1'b1);

    // Flush with a concurrent accept of rd=7.
    p = rand_payload(); p.rd = 5'd3;
    step(1'b1, p, 1'b0, 1'b0);
    p = rand_payload(); p.rd = 5'd7; p.reg_write = 1'b1;
    step(1'b1, p, 1'b0, 1'b1);
    repeat (2) idle(1'b1);

    // wb_sel and jump return address propagation.
    p = rand_payload(); p.wb_sel = WB_PC4; p.jump_result_plus4 = 32'h104;
    step(1'b1, p, 1'b1, 1'b0);
    p = rand_payload(); p.wb_sel = WB_MEM;
    step(1'b1, p, 1'b1, 1'b0);
    idle(1'b1);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_payload(),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // Long idle run: the bubble counter saturates and holds.
    repeat (20) idle(1'b1);

    // Asynchronous reset while a payload is held.
    p = rand_payload(); p.alu_out = 32'h1234; p.reg_write = 1'b1;
    step(1'b1, p, 1'b0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(1'b1);

    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
